// File: rtl/r2sdf_bf_stage.sv
// Radix-2 SDF (DIF) butterfly stage: pairs samples DEPTH apart through a feedback
// delay line and emits sums, then stored differences tagged for the twiddle multiplier.
module r2sdf_bf_stage #(
   parameter int IN_W      = 16,
   parameter int DEPTH     = 4,
   parameter int TW_STRIDE = 1,
   parameter int TW_AW     = $clog2(DEPTH*TW_STRIDE),
   parameter int SCALE     = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic signed [IN_W-1:0]  data_re_in,
   input  logic signed [IN_W-1:0]  data_im_in,
   input  logic                    flush,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic signed [IN_W-1:0]  data_re_out,
   output logic signed [IN_W-1:0]  data_im_out,
   output logic [TW_AW-1:0]        tw_idx,
   output logic                    tw_sel
);

   localparam int KW = $clog2(DEPTH);
   localparam int CW = KW + 1;

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t              r_state;
   state_t              w_stateNext;
   logic [CW-1:0]       r_cnt;
   logic [KW-1:0]       r_fIdx;
   logic                r_pending;
   logic [2*IN_W-1:0]   r_buf [DEPTH];

   logic                w_accept;
   logic                w_flushLast;
   logic                w_ready;
   logic [KW-1:0]       w_k;
   logic                w_ph;
   logic                w_lastK;
   logic [2*IN_W-1:0]   w_aRd;
   logic [2*IN_W-1:0]   w_fRd;
   logic [IN_W-1:0]     w_aRe;
   logic [IN_W-1:0]     w_aIm;
   logic [IN_W:0]       w_sumRe;
   logic [IN_W:0]       w_sumIm;
   logic [IN_W:0]       w_difRe;
   logic [IN_W:0]       w_difIm;
   logic [IN_W-1:0]     w_sumReS;
   logic [IN_W-1:0]     w_sumImS;
   logic [IN_W-1:0]     w_difReS;
   logic [IN_W-1:0]     w_difImS;
   logic [TW_AW-1:0]    w_twK;
   logic [TW_AW-1:0]    w_twF;

   assign w_k      = r_cnt[KW-1:0];
   assign w_ph     = r_cnt[CW-1];
   assign w_lastK  = (w_k == KW'(DEPTH-1));
   assign w_aRd    = r_buf[w_k];
   assign w_fRd    = r_buf[r_fIdx];
   assign w_aRe    = w_aRd[2*IN_W-1:IN_W];
   assign w_aIm    = w_aRd[IN_W-1:0];
   assign ready_in = w_ready;

   // One guard bit keeps the full sum/difference before scaling or wrapping.
   assign w_sumRe  = {w_aRe[IN_W-1], w_aRe} + {data_re_in[IN_W-1], data_re_in};
   assign w_sumIm  = {w_aIm[IN_W-1], w_aIm} + {data_im_in[IN_W-1], data_im_in};
   assign w_difRe  = {w_aRe[IN_W-1], w_aRe} - {data_re_in[IN_W-1], data_re_in};
   assign w_difIm  = {w_aIm[IN_W-1], w_aIm} - {data_im_in[IN_W-1], data_im_in};
   assign w_sumReS = (SCALE != 0) ? w_sumRe[IN_W:1] : w_sumRe[IN_W-1:0];
   assign w_sumImS = (SCALE != 0) ? w_sumIm[IN_W:1] : w_sumIm[IN_W-1:0];
   assign w_difReS = (SCALE != 0) ? w_difRe[IN_W:1] : w_difRe[IN_W-1:0];
   assign w_difImS = (SCALE != 0) ? w_difIm[IN_W:1] : w_difIm[IN_W-1:0];

   assign w_twK    = TW_AW'(32'(w_k) * TW_STRIDE);
   assign w_twF    = TW_AW'(32'(r_fIdx) * TW_STRIDE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_stateNext;
   end

   // Drain is only entered on an idle frame boundary with differences waiting.
   always_comb begin
      w_stateNext = r_state;
      w_ready     = 1'b0;
      w_accept    = 1'b0;
      w_flushLast = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_ready  = 1'b1;
            w_accept = valid_in;
            if (flush && !valid_in && r_pending && (r_cnt == '0))
               w_stateNext = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (r_fIdx == KW'(DEPTH-1)) begin
               w_flushLast = 1'b1;
               w_stateNext = ST_RUN;
            end
         end
         default: w_stateNext = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_fIdx      <= '0;
         r_pending   <= 1'b0;
         valid_out   <= 1'b0;
         data_re_out <= '0;
         data_im_out <= '0;
         tw_idx      <= '0;
         tw_sel      <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_ph) begin
               if (r_pending) begin
                  valid_out   <= 1'b1;
                  data_re_out <= w_aRe;
                  data_im_out <= w_aIm;
                  tw_idx      <= w_twK;
                  tw_sel      <= 1'b1;
               end
               if (w_lastK) r_pending <= 1'b0;
            end else begin
               valid_out   <= 1'b1;
               data_re_out <= w_sumReS;
               data_im_out <= w_sumImS;
               tw_idx      <= '0;
               tw_sel      <= 1'b0;
               if (w_lastK) r_pending <= 1'b1;
            end
         end
         if (r_state == ST_FLUSH) begin
            valid_out   <= 1'b1;
            data_re_out <= w_fRd[2*IN_W-1:IN_W];
            data_im_out <= w_fRd[IN_W-1:0];
            tw_idx      <= w_twF;
            tw_sel      <= 1'b1;
            r_fIdx      <= r_fIdx + 1'b1;
            if (w_flushLast) begin
               r_pending <= 1'b0;
               r_cnt     <= '0;
            end
         end
      end
   end

   // The delay line is deliberately left unreset; pending/cnt decide what is live.
   always_ff @(posedge clk) begin
      if (w_accept && !rst)
         r_buf[w_k] <= w_ph ? {w_difReS, w_difImS} : {data_re_in, data_im_in};
   end

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Directed bench for r2sdf_bf_stage: a SCALE=1 and a SCALE=0 instance share stimulus,
// table vectors cover frames/flush/reset/rounding, a hand-written run adds valid gaps.
module tb_r2sdf_bf_stage;

   typedef struct {
      logic vIn;
      int   reIn;
      int   imIn;
      logic fl;
      logic rs;
      logic eValid;
      logic eChk;
      logic eReady;
      int   eIdx;
      logic eSel;
      int   eRe1;
      int   eIm1;
      int   eRe0;
      int   eIm0;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               validIn;
   logic signed [15:0] dataReIn;
   logic signed [15:0] dataImIn;
   logic               flushIn;

   logic               ready1, validOut1, sel1;
   logic signed [15:0] reOut1, imOut1;
   logic [1:0]         idx1;
   logic               ready0, validOut0, sel0;
   logic signed [15:0] reOut0, imOut0;
   logic [1:0]         idx0;

   int testCount = 0;
   int failCount = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   r2sdf_bf_stage #(.IN_W(16), .DEPTH(4), .TW_STRIDE(1), .SCALE(1)) u_dutS1 (
      .clk(clk), .rst(rst), .valid_in(validIn),
      .data_re_in(dataReIn), .data_im_in(dataImIn), .flush(flushIn),
      .ready_in(ready1), .valid_out(validOut1),
      .data_re_out(reOut1), .data_im_out(imOut1),
      .tw_idx(idx1), .tw_sel(sel1)
   );

   r2sdf_bf_stage #(.IN_W(16), .DEPTH(4), .TW_STRIDE(1), .SCALE(0)) u_dutS0 (
      .clk(clk), .rst(rst), .valid_in(validIn),
      .data_re_in(dataReIn), .data_im_in(dataImIn), .flush(flushIn),
      .ready_in(ready0), .valid_out(validOut0),
      .data_re_out(reOut0), .data_im_out(imOut0),
      .tw_idx(idx0), .tw_sel(sel0)
   );

   function automatic vec_t mkQuiet(input logic vIn, input int re, input int im,
                                    input logic fl, input logic eReady);
      vec_t v;
      v = '{vIn, re, im, fl, 1'b0, 1'b0, 1'b0, eReady, 0, 1'b0, 0, 0, 0, 0};
      return v;
   endfunction

   function automatic vec_t mkWord(input logic vIn, input int re, input int im,
                                   input logic fl, input logic eReady, input int eIdx,
                                   input logic eSel, input int eRe1, input int eIm1,
                                   input int eRe0, input int eIm0);
      vec_t v;
      v = '{vIn, re, im, fl, 1'b0, 1'b1, 1'b1, eReady, eIdx, eSel, eRe1, eIm1, eRe0, eIm0};
      return v;
   endfunction

   function automatic vec_t mkReset();
      vec_t v;
      v = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 0, 0, 0};
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      validIn  = v.vIn;
      dataReIn = 16'(v.reIn);
      dataImIn = 16'(v.imIn);
      flushIn  = v.fl;
      rst      = v.rs;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOne(input int id, input string tag, input vec_t v,
                           input int eRe, input int eIm,
                           input logic aValid, input logic aReady, input int aRe,
                           input int aIm, input int aIdx, input logic aSel);
      logic ok;
      testCount++;
      ok = (aValid === v.eValid) && (aReady === v.eReady);
      if (v.eChk)
         ok = ok && (aRe == eRe) && (aIm == eIm) && (aIdx == v.eIdx) && (aSel === v.eSel);
      if (!ok) begin
         failCount++;
         $display("[TB] FAIL vec%0d %s: got v=%0b rdy=%0b re=%0d im=%0d idx=%0d sel=%0b, expected v=%0b rdy=%0b re=%0d im=%0d idx=%0d sel=%0b (data checked=%0b)",
                  id, tag, aValid, aReady, aRe, aIm, aIdx, aSel,
                  v.eValid, v.eReady, eRe, eIm, v.eIdx, v.eSel, v.eChk);
      end
   endtask

   task automatic checkOutput(input int id, input vec_t v);
      checkOne(id, "scale1", v, v.eRe1, v.eIm1, validOut1, ready1,
               int'(reOut1), int'(imOut1), int'(idx1), sel1);
      checkOne(id, "scale0", v, v.eRe0, v.eIm0, validOut0, ready0,
               int'(reOut0), int'(imOut0), int'(idx0), sel0);
   endtask

   initial begin
      vec_t v;
      validIn  = 1'b0;
      dataReIn = '0;
      dataImIn = '0;
      flushIn  = 1'b0;
      rst      = 1'b1;

      // Reset, then a flush with nothing pending must leave the stage in RUN.
      vecs.push_back(mkReset());
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b1, 1'b1));
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b0, 1'b1));

      // Frame A with a mid-frame flush request, then a real drain ignoring valid_in.
      vecs.push_back(mkQuiet(1'b1, 100, 0, 1'b0, 1'b1));
      vecs.push_back(mkQuiet(1'b1, 200, 0, 1'b0, 1'b1));
      vecs.push_back(mkQuiet(1'b1, 300, 0, 1'b0, 1'b1));
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b1, 1'b1));
      vecs.push_back(mkQuiet(1'b1, 400, 0, 1'b0, 1'b1));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mkWord(1'b1, 500 + 100*k, 0, 1'b0, 1'b1, 0, 1'b0,
                               300 + 100*k, 0, 600 + 200*k, 0));
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b1, 1'b0));
      for (int j = 0; j < 4; j++)
         vecs.push_back(mkWord(1'b1, 9999, 9999, 1'b0, (j == 3), j, 1'b1, -200, 0, -400, 0));
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b0, 1'b1));

      // Frames B and C back to back; C opens with a coincident flush and has a
      // mid-frame flush at cnt=3 while differences are still pending.
      for (int k = 0; k < 4; k++)
         vecs.push_back(mkQuiet(1'b1, 100 + 100*k, 0, 1'b0, 1'b1));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mkWord(1'b1, 500 + 100*k, 0, 1'b0, 1'b1, 0, 1'b0,
                               300 + 100*k, 0, 600 + 200*k, 0));
      for (int k = 0; k < 4; k++) begin
         if (k == 3) vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b1, 1'b1));
         vecs.push_back(mkWord(1'b1, 100 + 100*k, 0, (k == 0), 1'b1, k, 1'b1,
                               -200, 0, -400, 0));
      end
      for (int k = 0; k < 4; k++)
         vecs.push_back(mkWord(1'b1, 500 + 100*k, 0, 1'b0, 1'b1, 0, 1'b0,
                               300 + 100*k, 0, 600 + 200*k, 0));

      // Drain interrupted by reset after the second word; nothing may follow.
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b1, 1'b0));
      vecs.push_back(mkWord(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, -200, 0, -400, 0));
      vecs.push_back(mkWord(1'b0, 0, 0, 1'b0, 1'b0, 1, 1'b1, -200, 0, -400, 0));
      vecs.push_back(mkReset());
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b0, 1'b1));
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b0, 1'b1));
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b1, 1'b1));

      // Floor rounding of negatives (scale1) and two's-complement wrap (scale0).
      vecs.push_back(mkQuiet(1'b1, -3, 5, 1'b0, 1'b1));
      vecs.push_back(mkQuiet(1'b1, 32767, -32768, 1'b0, 1'b1));
      vecs.push_back(mkQuiet(1'b1, 7, -7, 1'b0, 1'b1));
      vecs.push_back(mkQuiet(1'b1, 0, 0, 1'b0, 1'b1));
      vecs.push_back(mkWord(1'b1, 0, 2, 1'b0, 1'b1, 0, 1'b0, -2, 3, -3, 7));
      vecs.push_back(mkWord(1'b1, 1, -1, 1'b0, 1'b1, 0, 1'b0, 16384, -16385, -32768, 32767));
      vecs.push_back(mkWord(1'b1, 2, 2, 1'b0, 1'b1, 0, 1'b0, 4, -3, 9, -5));
      vecs.push_back(mkWord(1'b1, 0, 0, 1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0));
      vecs.push_back(mkQuiet(1'b0, 0, 0, 1'b1, 1'b0));
      vecs.push_back(mkWord(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, -2, 1, -3, 3));
      vecs.push_back(mkWord(1'b0, 0, 0, 1'b0, 1'b0, 1, 1'b1, 16383, -16384, 32766, -32767));
      vecs.push_back(mkWord(1'b0, 0, 0, 1'b0, 1'b0, 2, 1'b1, 2, -5, 5, -9));
      vecs.push_back(mkWord(1'b0, 0, 0, 1'b0, 1'b1, 3, 1'b1, 0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(i, vecs[i]);
      end

      // Frame with random idle cycles: same words in the same order, no output on gaps.
      for (int i = 0; i < 8; i++) begin
         if (i == 2 || $urandom_range(1, 0) == 1) begin
            v = mkQuiet(1'b0, 0, 0, 1'b0, 1'b1);
            applyStimulus(v);
            checkOutput(100 + 2*i, v);
         end
         if (i < 4)
            v = mkQuiet(1'b1, 100 + 100*i, 10 + 10*i, 1'b0, 1'b1);
         else
            v = mkWord(1'b1, 100 + 100*i, 10 + 10*i, 1'b0, 1'b1, 0, 1'b0,
                       300 + 100*(i-4), 30 + 10*(i-4), 600 + 200*(i-4), 60 + 20*(i-4));
         applyStimulus(v);
         checkOutput(101 + 2*i, v);
      end
      v = mkQuiet(1'b0, 0, 0, 1'b1, 1'b0);
      applyStimulus(v);
      checkOutput(120, v);
      for (int j = 0; j < 4; j++) begin
         v = mkWord(1'b0, 0, 0, 1'b0, (j == 3), j, 1'b1, -200, -20, -400, -40);
         applyStimulus(v);
         checkOutput(121 + j, v);
      end
      v = mkQuiet(1'b0, 0, 0, 1'b0, 1'b1);
      applyStimulus(v);
      checkOutput(125, v);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
